mc_control: RTL and testbench

Multicycle successor to the single-cycle instruction decoder: a Moore/Mealy FSM that sequences each MIPS instruction through fetch, decode, execute, memory and writeback phases. It drives the datapath strobes, tolerates variable-latency memory through a ready handshake, and flags illegal encodings. It sits between the instruction register and the shared-memory datapath of the processor.

---
 rtl/mc_control.sv | 241 ++++++++++++++++++++++++
 tb/tb_mc_control.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mc_control
// Brief    : Multicycle MIPS control FSM. Sequences each instruction through
//            FETCH, DECODE, EXEC, MEM, WB (and MUL when enabled), drives the
//            datapath strobes and pulses illegal on undecodable encodings.
//            Optional macro MC_CONTROL_MULDIV_EN adds mult/mflo/mfhi support.
// Revision : 1.0 - initial release
// ============================================================================
module mc_control #(
    parameter int MUL_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [4:0] alufn,
    output logic       mem_req,
    output logic       mem_we,
    output logic       f_iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic [1:0] pc_src,
    output logic       f_dst_rt_rd,
    output logic       f_zeroextend,
    output logic       f_shiftval,
    output logic       f_alusrc,
    output logic       f_mem2reg,
    output logic       f_lui,
    output logic       f_link,
    output logic       mul_start,
    output logic       hilo_we,
    output logic       f_hilo,
    output logic       f_hi,
    output logic       illegal,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_MUL    = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_ILLEGAL, C_J, C_JAL, C_JR, C_LUI, C_RALU, C_IALU,
        C_BEQ, C_BNE, C_LW, C_SW, C_MULT, C_MFLO, C_MFHI
    } iclass_t;

    localparam logic [4:0] c_alu_add = 5'b00001;
    localparam logic [4:0] c_alu_sub = 5'b10001;
    localparam logic [4:0] c_alu_and = 5'b00000;
    localparam logic [4:0] c_alu_or  = 5'b00100;
    localparam logic [4:0] c_alu_xor = 5'b01000;
    localparam logic [4:0] c_alu_sll = 5'b00010;
    localparam logic [4:0] c_alu_sra = 5'b01010;
    localparam logic [4:0] c_alu_srl = 5'b01110;
    localparam logic [4:0] c_alu_slt = 5'b10011;
    localparam logic [5:0] c_mul_load = 6'(MUL_CYCLES - 1);

    state_t     r_state;
    logic       r_run;      // low during reset and until the first edge after release
    logic [5:0] r_mul_cnt;

    iclass_t    w_class;
    logic [4:0] w_alufn;
    logic       w_shift;
    logic       w_zext;

    assign state = r_state;

    // Classify the instruction held in the IR fields
    always_comb begin
        w_class = C_ILLEGAL;
        w_alufn = 5'b00000;
        w_shift = 1'b0;
        w_zext  = 1'b0;
        case (opcode)
            6'h00: begin
                case (func)
                    6'h20: begin w_class = C_RALU; w_alufn = c_alu_add; end
                    6'h22: begin w_class = C_RALU; w_alufn = c_alu_sub; end
                    6'h24: begin w_class = C_RALU; w_alufn = c_alu_and; end
                    6'h25: begin w_class = C_RALU; w_alufn = c_alu_or;  end
                    6'h26: begin w_class = C_RALU; w_alufn = c_alu_xor; end
                    6'h2a: begin w_class = C_RALU; w_alufn = c_alu_slt; end
                    6'h00: begin w_class = C_RALU; w_alufn = c_alu_sll; w_shift = 1'b1; end
                    6'h02: begin w_class = C_RALU; w_alufn = c_alu_srl; w_shift = 1'b1; end
                    6'h03: begin w_class = C_RALU; w_alufn = c_alu_sra; w_shift = 1'b1; end
                    6'h04: begin w_class = C_RALU; w_alufn = c_alu_sll; end
                    6'h06: begin w_class = C_RALU; w_alufn = c_alu_srl; end
                    6'h08: w_class = C_JR;
`ifdef MC_CONTROL_MULDIV_EN
                    6'h18: w_class = C_MULT;
                    6'h12: w_class = C_MFLO;
                    6'h10: w_class = C_MFHI;
`endif
                    default: w_class = C_ILLEGAL;
                endcase
            end
            6'h02: w_class = C_J;
            6'h03: w_class = C_JAL;
            6'h04: w_class = C_BEQ;
            6'h05: w_class = C_BNE;
            6'h08: begin w_class = C_IALU; w_alufn = c_alu_add; end
            6'h0a: begin w_class = C_IALU; w_alufn = c_alu_slt; end
            6'h0c: begin w_class = C_IALU; w_alufn = c_alu_and; w_zext = 1'b1; end
            6'h0d: begin w_class = C_IALU; w_alufn = c_alu_or;  w_zext = 1'b1; end
            6'h0e: begin w_class = C_IALU; w_alufn = c_alu_xor; w_zext = 1'b1; end
            6'h0f: w_class = C_LUI;
            6'h23: w_class = C_LW;
            6'h2b: w_class = C_SW;
            default: w_class = C_ILLEGAL;
        endcase
    end

    // State sequencing, multiply counter and run flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_run     <= 1'b0;
            r_mul_cnt <= c_mul_load;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                S_FETCH: if (r_run && mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (w_class)
                        C_J, C_JAL, C_JR, C_LUI, C_ILLEGAL: r_state <= S_FETCH;
                        C_MULT: begin
                            r_state   <= S_MUL;
                            r_mul_cnt <= c_mul_load;
                        end
                        default: r_state <= S_EXEC;
                    endcase
                end
                S_EXEC: r_state <= (w_class == C_LW || w_class == C_SW) ? S_MEM : S_FETCH;
                S_MEM: if (mem_ready) r_state <= (w_class == C_SW) ? S_FETCH : S_WB;
                S_WB: r_state <= S_FETCH;
                S_MUL: begin
                    if (r_mul_cnt == 6'd0) r_state <= S_FETCH;
                    else r_mul_cnt <= r_mul_cnt - 6'd1;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Datapath strobes; zero and mem_ready feed through combinationally
    always_comb begin
        alufn        = 5'b00000;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        f_iord       = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        reg_we       = 1'b0;
        pc_src       = 2'd0;
        f_dst_rt_rd  = 1'b0;
        f_zeroextend = 1'b0;
        f_shiftval   = 1'b0;
        f_alusrc     = 1'b0;
        f_mem2reg    = 1'b0;
        f_lui        = 1'b0;
        f_link       = 1'b0;
        mul_start    = 1'b0;
        hilo_we      = 1'b0;
        f_hilo       = 1'b0;
        f_hi         = 1'b0;
        illegal      = 1'b0;
        if (r_run) begin
            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                    pc_we   = mem_ready;
                end
                S_DECODE: begin
                    case (w_class)
                        C_J:   begin pc_we = 1'b1; pc_src = 2'd2; end
                        C_JAL: begin pc_we = 1'b1; pc_src = 2'd2; reg_we = 1'b1; f_link = 1'b1; end
                        C_JR:  begin pc_we = 1'b1; pc_src = 2'd3; end
                        C_LUI: begin reg_we = 1'b1; f_lui = 1'b1; end
                        C_ILLEGAL: illegal = 1'b1;
`ifdef MC_CONTROL_MULDIV_EN
                        C_MULT: mul_start = 1'b1;
`endif
                        default: ;
                    endcase
                end
                S_EXEC: begin
                    case (w_class)
                        C_RALU: begin
                            alufn       = w_alufn;
                            reg_we      = 1'b1;
                            f_dst_rt_rd = 1'b1;
                            f_shiftval  = w_shift;
                        end
                        C_IALU: begin
                            alufn        = w_alufn;
                            reg_we       = 1'b1;
                            f_alusrc     = 1'b1;
                            f_zeroextend = w_zext;
                        end
                        C_BEQ: begin alufn = c_alu_sub; pc_we = zero;  pc_src = 2'd1; end
                        C_BNE: begin alufn = c_alu_sub; pc_we = !zero; pc_src = 2'd1; end
                        C_LW, C_SW: begin alufn = c_alu_add; f_alusrc = 1'b1; end
`ifdef MC_CONTROL_MULDIV_EN
                        C_MFLO: begin reg_we = 1'b1; f_dst_rt_rd = 1'b1; f_hilo = 1'b1; end
                        C_MFHI: begin reg_we = 1'b1; f_dst_rt_rd = 1'b1; f_hilo = 1'b1; f_hi = 1'b1; end
`endif
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    f_iord  = 1'b1;
                    mem_we  = (w_class == C_SW);
                end
                S_WB: begin
                    reg_we    = 1'b1;
                    f_mem2reg = 1'b1;
                end
                S_MUL: begin
`ifdef MC_CONTROL_MULDIV_EN
                    hilo_we = (r_mul_cnt == 6'd0);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control
// Brief    : Directed self-checking bench for mc_control. All outputs are
//            packed into one vector and compared against hand-built values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;
    logic [4:0] alufn;
    logic       mem_req, mem_we, f_iord, ir_we, pc_we, reg_we;
    logic [1:0] pc_src;
    logic       f_dst_rt_rd, f_zeroextend, f_shiftval, f_alusrc, f_mem2reg, f_lui, f_link;
    logic       mul_start, hilo_we, f_hilo, f_hi, illegal;
    logic [2:0] state;

    typedef struct packed {
        logic [4:0] alufn;
        logic       mem_req, mem_we, f_iord, ir_we, pc_we, reg_we;
        logic [1:0] pc_src;
        logic       dst, zext, shv, alusrc, m2r, lui, link;
        logic       mul_start, hilo_we, hilo, hi, ill;
        logic [2:0] st;
    } ov_t;

    ov_t obs;
    ov_t e;
    int  n_tests = 0;
    int  n_fail  = 0;

    assign obs = {alufn, mem_req, mem_we, f_iord, ir_we, pc_we, reg_we, pc_src,
                  f_dst_rt_rd, f_zeroextend, f_shiftval, f_alusrc, f_mem2reg, f_lui, f_link,
                  mul_start, hilo_we, f_hilo, f_hi, illegal, state};

    mc_control #(.MUL_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .alufn(alufn), .mem_req(mem_req), .mem_we(mem_we),
        .f_iord(f_iord), .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .pc_src(pc_src),
        .f_dst_rt_rd(f_dst_rt_rd), .f_zeroextend(f_zeroextend), .f_shiftval(f_shiftval),
        .f_alusrc(f_alusrc), .f_mem2reg(f_mem2reg), .f_lui(f_lui), .f_link(f_link),
        .mul_start(mul_start), .hilo_we(hilo_we), .f_hilo(f_hilo), .f_hi(f_hi),
        .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %07h expected %07h", tag, got, exp);
        end
    endtask

    // Move just past the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let inputs settle, then compare the full output vector
    task automatic expect_v(input string tag, input ov_t ex);
        #1;
        check(tag, {4'b0, obs}, {4'b0, ex});
    endtask

    // Complete a zero-wait fetch of the given instruction, ending in DECODE
    task automatic fetch(input string tag, input logic [5:0] op, input logic [5:0] fn);
        ov_t f;
        mem_ready = 1'b1;
        opcode    = op;
        func      = fn;
        f = '0; f.mem_req = 1'b1; f.ir_we = 1'b1; f.pc_we = 1'b1; f.st = 3'd0;
        expect_v(tag, f);
        step();
    endtask

    initial begin
        reset = 1'b1; opcode = 6'h00; func = 6'h00; zero = 1'b0; mem_ready = 1'b0;

        // Reset holds everything low
        step();
        e = '0; expect_v("reset", e);
        step();
        reset = 1'b0;
        e = '0; expect_v("post_release", e);
        step();

        // add: FETCH -> DECODE -> EXEC -> FETCH
        fetch("add_fetch", 6'h00, 6'h20);
        e = '0; e.st = 3'd1; expect_v("add_decode", e);
        step();
        e = '0; e.alufn = 5'b00001; e.reg_we = 1'b1; e.dst = 1'b1; e.st = 3'd2;
        expect_v("add_exec", e);
        step();

        // lw with three wait cycles in MEM
        fetch("lw_fetch", 6'h23, 6'h00);
        mem_ready = 1'b0;
        e = '0; e.st = 3'd1; expect_v("lw_decode", e);
        step();
        e = '0; e.alufn = 5'b00001; e.alusrc = 1'b1; e.st = 3'd2;
        expect_v("lw_exec", e);
        step();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            e = '0; e.mem_req = 1'b1; e.f_iord = 1'b1; e.st = 3'd3;
            expect_v("lw_mem", e);
            step();
        end
        mem_ready = 1'b1;
        e = '0; e.reg_we = 1'b1; e.m2r = 1'b1; e.st = 3'd4;
        expect_v("lw_wb", e);
        step();

        // Branches: {beq,bne} x {zero=1,zero=0}
        for (int b = 0; b < 4; b++) begin
            fetch("br_fetch", (b < 2) ? 6'h04 : 6'h05, 6'h00);
            step();
            zero = (b == 0 || b == 2);
            e = '0; e.alufn = 5'b10001; e.pc_src = 2'd1; e.st = 3'd2;
            e.pc_we = (b == 0 || b == 3);
            expect_v("br_exec", e);
            step();
        end
        zero = 1'b0;

        // Illegal opcode: one-cycle pulse in DECODE, no writes
        fetch("ill_fetch", 6'h3f, 6'h00);
        mem_ready = 1'b0;
        e = '0; e.ill = 1'b1; e.st = 3'd1; expect_v("ill_decode", e);
        step();
        e = '0; e.mem_req = 1'b1; e.st = 3'd0; expect_v("ill_back_fetch", e);
        step();

        // Decode-completing ops
        fetch("j_fetch", 6'h02, 6'h00);
        e = '0; e.pc_we = 1'b1; e.pc_src = 2'd2; e.st = 3'd1; expect_v("j_decode", e);
        step();
        fetch("jal_fetch", 6'h03, 6'h00);
        e = '0; e.pc_we = 1'b1; e.pc_src = 2'd2; e.reg_we = 1'b1; e.link = 1'b1; e.st = 3'd1;
        expect_v("jal_decode", e);
        step();
        fetch("jr_fetch", 6'h00, 6'h08);
        e = '0; e.pc_we = 1'b1; e.pc_src = 2'd3; e.st = 3'd1; expect_v("jr_decode", e);
        step();
        fetch("lui_fetch", 6'h0f, 6'h00);
        e = '0; e.reg_we = 1'b1; e.lui = 1'b1; e.st = 3'd1; expect_v("lui_decode", e);
        step();

        // Immediate and shift ALU ops
        fetch("andi_fetch", 6'h0c, 6'h00);
        step();
        e = '0; e.alufn = 5'b00000; e.reg_we = 1'b1; e.alusrc = 1'b1; e.zext = 1'b1; e.st = 3'd2;
        expect_v("andi_exec", e);
        step();
        fetch("sll_fetch", 6'h00, 6'h00);
        step();
        e = '0; e.alufn = 5'b00010; e.reg_we = 1'b1; e.dst = 1'b1; e.shv = 1'b1; e.st = 3'd2;
        expect_v("sll_exec", e);
        step();
        fetch("slti_fetch", 6'h0a, 6'h00);
        step();
        e = '0; e.alufn = 5'b10011; e.reg_we = 1'b1; e.alusrc = 1'b1; e.st = 3'd2;
        expect_v("slti_exec", e);
        step();
        fetch("sra_fetch", 6'h00, 6'h03);
        step();
        e = '0; e.alufn = 5'b01010; e.reg_we = 1'b1; e.dst = 1'b1; e.shv = 1'b1; e.st = 3'd2;
        expect_v("sra_exec", e);
        step();

        // sw with reset asserted mid-MEM
        fetch("sw_fetch", 6'h2b, 6'h00);
        step();
        e = '0; e.alufn = 5'b00001; e.alusrc = 1'b1; e.st = 3'd2; expect_v("sw_exec", e);
        step();
        mem_ready = 1'b0;
        e = '0; e.mem_req = 1'b1; e.mem_we = 1'b1; e.f_iord = 1'b1; e.st = 3'd3;
        expect_v("sw_mem", e);
        #2 reset = 1'b1;
        e = '0; expect_v("sw_reset_drop", e);
        step();
        reset = 1'b0;
        e = '0; expect_v("sw_release", e);
        step();
        e = '0; e.mem_req = 1'b1; e.st = 3'd0; expect_v("sw_refetch", e);

`ifdef MC_CONTROL_MULDIV_EN
        // mult with MUL_CYCLES=4, then mflo and mfhi
        fetch("mult_fetch", 6'h00, 6'h18);
        e = '0; e.mul_start = 1'b1; e.st = 3'd1; expect_v("mult_decode", e);
        step();
        for (int i = 0; i < 4; i++) begin
            e = '0; e.st = 3'd5; e.hilo_we = (i == 3);
            expect_v("mult_mul", e);
            step();
        end
        fetch("mflo_fetch", 6'h00, 6'h12);
        step();
        e = '0; e.reg_we = 1'b1; e.dst = 1'b1; e.hilo = 1'b1; e.st = 3'd2;
        expect_v("mflo_exec", e);
        step();
        fetch("mfhi_fetch", 6'h00, 6'h10);
        step();
        e = '0; e.reg_we = 1'b1; e.dst = 1'b1; e.hilo = 1'b1; e.hi = 1'b1; e.st = 3'd2;
        expect_v("mfhi_exec", e);
        step();
`else
        // Multiplier encodings are illegal without the feature
        fetch("mult_fetch", 6'h00, 6'h18);
        e = '0; e.ill = 1'b1; e.st = 3'd1; expect_v("mult_illegal", e);
        step();
        fetch("mflo_fetch", 6'h00, 6'h12);
        e = '0; e.ill = 1'b1; e.st = 3'd1; expect_v("mflo_illegal", e);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
